exec_unit_mc: RTL and testbench

Parametrised successor to the single-cycle execute stage. Adds a registered result/flag path, an iterative multi-cycle multiplier with a stall handshake, flag set/clear operations and a pipeline flush. Sits between the decode/register-read pipeline register and the memory stage. Owns the architectural Z/N/C flag register.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/mul_seq.sv | 78 +++++++
 rtl/exec_unit_mc.sv | 144 ++++++++++++++
 tb/tb_exec_unit_mc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types for the multi-cycle execute stage.
//   op_e    - 4-bit operation codes (14/15 unassigned, treated as NOP)
//   FLAG_*  - bit positions inside the {C,N,Z} flag register
//   state_e - multiplier sequencer state
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_NOT  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10,
    OP_SETC = 4'd11,
    OP_CLRC = 4'd12,
    OP_MOV  = 4'd13
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// mul_seq: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - latch a/b and begin (honoured only when idle)
//   a, b        - operands
//   kill        - abandon the multiply in flight
//   busy        - registered: a multiply is in progress
//   done        - this cycle performs the final step (not killed)
//   prod        - product value being written on this edge; valid with done
module mul_seq
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               kill,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  state_e              r_state;
  state_e              w_state_next;
  logic [CW-1:0]       r_count;
  logic [WIDTH-1:0]    r_mcand;
  // {accumulator, remaining multiplier bits}; shifts right every step
  logic [2*WIDTH-1:0]  r_prod;
  logic [WIDTH-1:0]    w_addend;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_prod_next;
  logic                w_last;

  assign w_addend    = r_prod[0] ? r_mcand : '0;
  assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
  assign w_last      = (r_state == BUSY) && (r_count == CW'(WIDTH - 1));

  assign busy = (r_state == BUSY);
  assign done = w_last && !kill;
  assign prod = w_prod_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = BUSY;
      BUSY:    if (kill || w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_count <= '0;
        r_mcand <= a;
        r_prod  <= {{WIDTH{1'b0}}, b};
      end
    end else begin
      r_count <= r_count + 1'b1;
      r_prod  <= w_prod_next;
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: execute stage with registered results/flags, a multi-cycle
// multiplier with stall handshake, flag set/clear ops and pipeline flush.
//   clk, rst_n        - clock, asynchronous active-low reset
//   inValid, op       - instruction strobe and op_e code
//   aluSrc            - 0: in1 = readData1, 1: in1 = immediateValue
//   readData1/2       - register operands (readData2 is in2)
//   immediateValue    - immediate; low SHW bits are the shift amount
//   flush             - kill the in-flight / same-cycle instruction
//   stall             - multiplier busy, upstream must hold
//   outValid          - one-cycle pulse per completed instruction
//   aluResult/Hi      - result (Hi = product high half, 0 otherwise)
//   flags             - registered {C,N,Z}
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  input  logic [3:0]       op,
  input  logic             aluSrc,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] immediateValue,
  input  logic             flush,
  output logic             stall,
  output logic             outValid,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] aluResultHi,
  output logic [2:0]       flags
);

  op_e                w_op;
  logic [WIDTH-1:0]   w_in1;
  logic [WIDTH-1:0]   w_in2;
  logic [SHW-1:0]     w_shamt;
  logic               w_accept;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_upd_zn;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic [2:0]         r_flags;

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  assign w_op     = op_e'(op);
  assign w_in1    = aluSrc ? immediateValue : readData1;
  assign w_in2    = readData2;
  assign w_shamt  = immediateValue[SHW-1:0];
  assign w_accept = inValid && !w_mul_busy && !flush;

  // Widened shifts: the extra bit catches the last bit shifted out
  assign w_shl = {1'b0, w_in1} << w_shamt;
  assign w_shr = {w_in1, 1'b0} >> w_shamt;

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept && (w_op == OP_MUL)),
    .a     (w_in1),
    .b     (w_in2),
    .kill  (flush),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .prod  (w_prod)
  );

  always_comb begin
    w_res    = '0;
    w_c      = r_flags[FLAG_C];
    w_upd_zn = 1'b1;
    case (w_op)
      OP_ADD:  {w_c, w_res} = {1'b0, w_in1} + {1'b0, w_in2};
      OP_SUB:  {w_c, w_res} = {1'b0, w_in1} - {1'b0, w_in2};
      OP_AND:  w_res = w_in1 & w_in2;
      OP_OR:   w_res = w_in1 | w_in2;
      OP_NOT:  w_res = ~w_in1;
      OP_MOV:  w_res = w_in1;
      OP_INC:  {w_c, w_res} = {1'b0, w_in1} + ONE;
      OP_DEC:  {w_c, w_res} = {1'b0, w_in1} - ONE;
      OP_SHL: begin
        w_res = w_in1;
        if (w_shamt != '0) {w_c, w_res} = w_shl;
      end
      OP_SHR: begin
        w_res = w_in1;
        if (w_shamt != '0) {w_res, w_c} = w_shr;
      end
      OP_SETC: begin
        w_c      = 1'b1;
        w_upd_zn = 1'b0;
      end
      OP_CLRC: begin
        w_c      = 1'b0;
        w_upd_zn = 1'b0;
      end
      default: w_upd_zn = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else if (w_mul_done) begin
      r_out_valid     <= 1'b1;
      r_result        <= w_prod[WIDTH-1:0];
      r_result_hi     <= w_prod[2*WIDTH-1:WIDTH];
      r_flags[FLAG_Z] <= ~|w_prod;
      r_flags[FLAG_N] <= w_prod[WIDTH-1];
      r_flags[FLAG_C] <= |w_prod[2*WIDTH-1:WIDTH];
    end else if (w_accept && (w_op != OP_MUL)) begin
      r_out_valid     <= 1'b1;
      r_result        <= w_res;
      r_result_hi     <= '0;
      r_flags[FLAG_C] <= w_c;
      if (w_upd_zn) begin
        r_flags[FLAG_Z] <= (w_res == '0);
        r_flags[FLAG_N] <= w_res[WIDTH-1];
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign stall       = w_mul_busy;
  assign outValid    = r_out_valid;
  assign aluResult   = r_result;
  assign aluResultHi = r_result_hi;
  assign flags       = r_flags;

endmodule

// File: tb/tb_exec_unit_mc.sv
module tb_exec_unit_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid;
  logic [3:0]   op;
  logic         aluSrc;
  logic [W-1:0] readData1;
  logic [W-1:0] readData2;
  logic [W-1:0] immediateValue;
  logic         flush;
  logic         stall;
  logic         outValid;
  logic [W-1:0] aluResult;
  logic [W-1:0] aluResultHi;
  logic [2:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int           m_cnt;   // stall cycles still to come for the active MUL
  logic         m_ov;
  logic [W-1:0] m_lo, m_hi, m_plo, m_phi;
  logic [2:0]   m_fl, m_pfl;

  exec_unit_mc #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inValid        (inValid),
    .op             (op),
    .aluSrc         (aluSrc),
    .readData1      (readData1),
    .readData2      (readData2),
    .immediateValue (immediateValue),
    .flush          (flush),
    .stall          (stall),
    .outValid       (outValid),
    .aluResult      (aluResult),
    .aluResultHi    (aluResultHi),
    .flags          (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ov = 1'b0; m_lo = '0; m_hi = '0; m_fl = '0;
    m_plo = '0; m_phi = '0; m_pfl = '0;
  endtask

  // Architectural behaviour of one single-cycle op, from the op table.
  task automatic ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned s, input logic [2:0] fin,
                         output logic [W-1:0] res, output logic [2:0] fout);
    longint unsigned ai = a;
    longint unsigned bi = b;
    longint unsigned maxv = (64'd1 << W) - 1;
    logic c    = fin[2];
    logic keep = 1'b0;
    res = '0;
    case (o)
      4'd1:  begin res = W'(ai + bi); c = (ai + bi) > maxv; end
      4'd2:  begin res = W'(ai - bi); c = ai < bi; end
      4'd3:  res = a & b;
      4'd4:  res = a | b;
      4'd5:  res = ~a;
      4'd13: res = a;
      4'd6:  begin res = W'(ai + 1); c = (ai == maxv); end
      4'd7:  begin res = W'(ai - 1); c = (ai == 0); end
      4'd8:  begin
        res = W'(ai << s);
        if (s != 0) c = ((ai >> (W - s)) & 1) != 0;
      end
      4'd9:  begin
        res = W'(ai >> s);
        if (s != 0) c = ((ai >> (s - 1)) & 1) != 0;
      end
      4'd11: begin c = 1'b1; keep = 1'b1; end
      4'd12: begin c = 1'b0; keep = 1'b1; end
      default: keep = 1'b1;
    endcase
    fout = keep ? {c, fin[1:0]} : {c, res[W-1], res == 0};
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_edge();
    logic [W-1:0] in1, r;
    logic [2:0]   f;
    longint unsigned p;
    in1 = aluSrc ? immediateValue : readData1;
    if (m_cnt > 0) begin
      if (flush) begin
        m_cnt = 0; m_ov = 1'b0;
      end else begin
        m_cnt--;
        m_ov = (m_cnt == 0);
        if (m_ov) begin m_lo = m_plo; m_hi = m_phi; m_fl = m_pfl; end
      end
    end else if (inValid && !flush) begin
      if (op == 4'd10) begin
        p     = longint'(in1) * longint'(readData2);
        m_plo = W'(p);
        m_phi = W'(p >> W);
        m_pfl = {m_phi != 0, m_plo[W-1], p == 0};
        m_cnt = W;
        m_ov  = 1'b0;
      end else begin
        ref_alu(op, in1, readData2, int'(immediateValue % W), m_fl, r, f);
        m_ov = 1'b1; m_lo = r; m_hi = '0; m_fl = f;
      end
    end else begin
      m_ov = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("stall",       32'(stall),       32'(m_cnt > 0));
    chk("outValid",    32'(outValid),    32'(m_ov));
    chk("aluResult",   32'(aluResult),   32'(m_lo));
    chk("aluResultHi", 32'(aluResultHi), 32'(m_hi));
    chk("flags",       32'(flags),       32'(m_fl));
  endtask

  task automatic step(input logic v, input logic [3:0] o, input logic src,
                      input logic [W-1:0] r1, input logic [W-1:0] r2,
                      input logic [W-1:0] im, input logic fl);
    inValid = v; op = o; aluSrc = src; readData1 = r1; readData2 = r2;
    immediateValue = im; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    int cyc, st_cyc;
    rst_n = 1'b0;
    inValid = 1'b0; op = '0; aluSrc = 1'b0; readData1 = '0; readData2 = '0;
    immediateValue = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;

    // ADD carry out to zero
    step(1'b1, 4'd1, 1'b0, 16'hFFFF, 16'h0001, '0, 1'b0);
    chk("add_result", 32'(aluResult), 32'h0);
    chk("add_flags",  32'(flags),     32'b101);

    // SUB borrow, then AND to zero keeps C
    step(1'b1, 4'd2, 1'b0, 16'h0003, 16'h0005, '0, 1'b0);
    chk("sub_result", 32'(aluResult), 32'hFFFE);
    chk("sub_flags",  32'(flags),     32'b110);
    step(1'b1, 4'd3, 1'b0, 16'h00F0, 16'h0F00, '0, 1'b0);
    chk("and_flags",  32'(flags),     32'b101);

    // MUL with inValid held high through the stall
    step(1'b1, 4'd10, 1'b0, 16'h00FF, 16'h0101, '0, 1'b0);
    cyc = 1; st_cyc = stall ? 1 : 0;
    while (!outValid && cyc < 40) begin
      step(1'b1, 4'd10, 1'b0, 16'h00FF, 16'h0101, '0, 1'b0);
      cyc++;
      if (stall) st_cyc++;
    end
    chk("mul1_latency", 32'(cyc), 32'd17);
    chk("mul1_stall",   32'(st_cyc), 32'd16);
    chk("mul1_lo",      32'(aluResult), 32'hFFFF);
    chk("mul1_hi",      32'(aluResultHi), 32'h0);
    chk("mul1_c",       32'(flags[2]), 32'h0);
    idle();

    // MUL high half, then back-to-back ADD in the outValid cycle
    step(1'b1, 4'd10, 1'b0, 16'h8000, 16'h0004, '0, 1'b0);
    cyc = 1;
    while (!outValid && cyc < 40) begin idle(); cyc++; end
    chk("mul2_latency", 32'(cyc), 32'd17);
    chk("mul2_lo",      32'(aluResult), 32'h0);
    chk("mul2_hi",      32'(aluResultHi), 32'h2);
    chk("mul2_flags",   32'(flags), 32'b100);
    step(1'b1, 4'd1, 1'b0, 16'h0010, 16'h0020, '0, 1'b0);
    chk("b2b_valid",  32'(outValid), 32'h1);
    chk("b2b_result", 32'(aluResult), 32'h0030);

    // Flush in the 5th BUSY cycle
    step(1'b1, 4'd10, 1'b0, 16'h1234, 16'h0077, '0, 1'b0);
    repeat (4) idle();
    step(1'b0, 4'd0, 1'b0, '0, '0, '0, 1'b1);
    chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_valid", 32'(outValid), 32'h0);
    chk("flush_flags", 32'(flags), 32'b000);
    step(1'b1, 4'd8, 1'b0, 16'h8001, '0, 16'h0001, 1'b0);
    chk("shl_result", 32'(aluResult), 32'h0002);
    chk("shl_c",      32'(flags[2]), 32'h1);

    // Same-cycle flush in IDLE drops the instruction
    step(1'b1, 4'd13, 1'b0, 16'h5555, '0, '0, 1'b1);

    // Asynchronous reset mid-MUL
    step(1'b1, 4'd10, 1'b0, 16'hFFFF, 16'hFFFF, '0, 1'b0);
    repeat (3) idle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 4'd11, 1'b0, '0, '0, '0, 1'b0);
    chk("setc_flags", 32'(flags), 32'b100);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, 4'($urandom_range(15, 0)), 1'($urandom),
           W'($urandom), W'($urandom), W'($urandom), $urandom_range(11, 0) == 0);
    end
    repeat (W + 2) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
